hitcomb_seq: RTL and testbench
==============================

# hitcomb_seq

Combination sequencer for the hit-memory readout path. It sits directly downstream of the per-layer hit memories and their position counters. For one road, it walks every combination of one hit per layer in odometer order. For each combination it presents the per-layer read positions, with a valid/ready handshake, to the fitter input stage. It finishes with a done pulse and a combination count.

## Interface
Parameters:
- NLAYER, 6, number of detector layers (2..8)
- PW, 5, per-layer hit-position width; a layer holds up to 2^PW-1 = 31 hits
- CW, 16, width of the combination counter

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  one-cycle request to begin a road; honoured only in IDLE
- nhits  in  NLAYER*PW  hit count per layer, layer k at bits [k*PW +: PW]; sampled only on an accepted start
- abort  in  1  synchronous cancel; effective in any state
- fit_ready  in  1  fitter can accept a combination this cycle
- comb_valid  out  1  pos holds a valid combination
- pos  out  NLAYER*PW  hit position per layer, same packing as nhits
- comb_last  out  1  qualifies comb_valid; this is the final combination of the road
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a road
- nocomb  out  1  road had a zero-hit layer; valid while done is high
- ncomb  out  CW  combinations accepted by the fitter this road; saturates at 2^CW-1; held until the next accepted start

## Operation
- FSM states: IDLE, CHECK, RUN, DONE.
- **IDLE.** On start, latch nhits into internal count registers, clear ncomb, and go to CHECK.
- **CHECK.** This state lasts one cycle.
  - If any latched count is 0: set nocomb and go to DONE.
  - Otherwise: clear nocomb, set all pos to 0, set comb_valid, and go to RUN.
- **RUN.** A transfer occurs when comb_valid and fit_ready are both high. On each transfer, ncomb increments (saturating).
  - If comb_last is high: clear comb_valid and go to DONE.
  - Otherwise, advance the odometer. Layer 0 is the fastest digit. Layer k advances only when every layer j<k is at its last position (pos_j == count_j-1). A layer at its last position that advances wraps to 0; otherwise it increments by 1.
- comb_last = AND over all layers of (pos_k == count_k-1). It is combinational from the registered pos and counts.
- A layer with count 1 is always at its last position, so it never moves.
- **DONE.** Assert done for one cycle, then go to IDLE.
- Boundary conditions:
  - **abort**, in any state: next state IDLE; comb_valid, comb_last, and done are low from the next cycle; no done pulse; ncomb holds its last value. abort takes priority over start and over a simultaneous transfer. A transfer in the same cycle as abort still counts in ncomb.
  - **start while busy:** ignored, and nhits is not resampled.
  - **nhits changes after latch:** no effect on the road in progress.
  - **reset mid-road:** all outputs go to 0 immediately and the state goes to IDLE.
- Arithmetic:
  - count-1 is computed at PW bits and is only evaluated for nonzero counts.
  - ncomb uses CW-bit saturating arithmetic.
- Total combinations per road = product of all counts, with a maximum of 31^6. ncomb saturates well below this maximum; it does not wrap.

## Timing
- Reset values: comb_valid=0, pos=0, comb_last=0, busy=0, done=0, nocomb=0, ncomb=0; state IDLE.
- Start latency:
  - start sampled at edge E0 → busy high after E0.
  - First comb_valid with pos=0 is high after E1.
  - For a zero-hit road, done and nocomb are high after E1.
- Throughput: one combination per cycle while fit_ready is held high.
- Backpressure: while comb_valid=1 and fit_ready=0, pos and comb_last hold stable.
- Completion: the final transfer at edge En gives comb_valid=0 and done=1 after En, then busy=0 after En+1.
- A new start may be accepted in the cycle after done; it cannot be accepted in the done cycle itself.

## Test plan
1. **Minimal road.** NLAYER=6, all nhits=1, fit_ready=1, start → exactly one combination with pos all 0 and comb_last=1; done one cycle later; ncomb=1; nocomb=0.
2. **Odometer order.** nhits = {layer0=3, layer1=2, rest=1}, fit_ready=1 → (l0,l1) sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on 6 consecutive cycles; comb_last only on the 6th; ncomb=6.
3. **Backpressure.** Same road as scenario 2 with fit_ready toggling in the pattern 1,0,0,1,… → pos stable during every stall; same 6-entry order; done only after the 6th transfer.
4. **Zero-hit road.** nhits layer3=0, others 4 → comb_valid never asserted; done and nocomb high for one cycle, 2 edges after start; ncomb=0.
5. **abort then restart.** abort after 3 transfers on a 4×4 road → comb_valid low next cycle, no done pulse, ncomb=3. A fresh start then runs 16 combinations normally, ending with ncomb=16.
6. **Robustness and saturation.**
   - Assert reset asynchronously mid-RUN → outputs go to 0 immediately.
   - Pulse start while busy, and change nhits during a run → both ignored.
   - With CW=4, run a road of 31×1 combinations → ncomb saturates at 15.

Source files
------------

// File: rtl/hitcomb_seq.sv
// ----------------------------------------------------------------------------
// hitcomb_seq
//
// Combination sequencer for the hit-memory readout path. For one road it
// walks every combination of one hit per layer in odometer order (layer 0 is
// the fastest digit). Each combination is offered to the fitter input stage
// with a valid/ready handshake. The road ends with a one-cycle done pulse and
// a saturating count of accepted combinations.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high; clears all state and outputs
//   start       in   one-cycle request to begin a road (honoured in IDLE only)
//   nhits       in   hit count per layer, layer k at [k*PW +: PW]
//   abort       in   synchronous cancel, any state, highest priority
//   fit_ready   in   fitter accepts a combination this cycle
//   comb_valid  out  pos holds a valid combination
//   pos         out  hit position per layer, same packing as nhits
//   comb_last   out  qualifies comb_valid: final combination of the road
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at the end of a road
//   nocomb      out  road had a zero-hit layer; valid while done is high
//   ncomb       out  combinations accepted this road (saturating)
// ----------------------------------------------------------------------------
module hitcomb_seq #(
  parameter int NLAYER = 6,
  parameter int PW     = 5,
  parameter int CW     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NLAYER*PW-1:0] nhits,
  input  logic                 abort,
  input  logic                 fit_ready,
  output logic                 comb_valid,
  output logic [NLAYER*PW-1:0] pos,
  output logic                 comb_last,
  output logic                 busy,
  output logic                 done,
  output logic                 nocomb,
  output logic [CW-1:0]        ncomb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE   = PW'(1'b1);
  localparam logic [CW-1:0] NCOMB_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] NCOMB_ONE = CW'(1'b1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [NLAYER*PW-1:0]   cnt_r;
  logic [NLAYER*PW-1:0]   pos_r;
  logic [NLAYER*PW-1:0]   pos_adv_s;
  logic [NLAYER-1:0]      zero_s;
  logic [NLAYER-1:0]      last_s;
  logic                   carry_s;
  logic                   any_zero_s;
  logic                   all_last_s;
  logic                   comb_valid_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   nocomb_r;
  logic [CW-1:0]          ncomb_r;
  logic                   load_s;
  logic                   xfer_s;
  logic                   comb_last_s;

  // Start is only taken in IDLE, and abort wins over a simultaneous start.
  assign load_s = (state_r == IDLE) && start && !abort;

  // comb_valid is only ever high in RUN, so this is the fitter handshake.
  assign xfer_s = comb_valid_r && fit_ready && (state_r == RUN);

  // Per-layer status: empty layer, and layer sitting at its last position.
  always_comb begin
    zero_s = {NLAYER{1'b0}};
    last_s = {NLAYER{1'b0}};
    for (int k = 0; k < NLAYER; k++) begin
      zero_s[k] = (cnt_r[k*PW +: PW] == POS_ZERO);
      // count-1 only matters for a non-empty layer; an empty layer never runs.
      if (zero_s[k]) begin
        last_s[k] = 1'b0;
      end else begin
        last_s[k] = (pos_r[k*PW +: PW] == (cnt_r[k*PW +: PW] - POS_ONE));
      end
    end
  end

  assign any_zero_s = |zero_s;
  assign all_last_s = &last_s;

  // Gated by comb_valid so a stale final position never shows as last
  // outside an active offer (after abort, after done, in IDLE).
  assign comb_last_s = comb_valid_r && all_last_s;

  // Odometer step: the carry enters layer 0 and ripples past every layer
  // that is at its last position; a carried-into layer wraps or increments.
  always_comb begin
    pos_adv_s = pos_r;
    carry_s   = 1'b1;
    for (int k = 0; k < NLAYER; k++) begin
      if (carry_s) begin
        if (last_s[k]) begin
          pos_adv_s[k*PW +: PW] = POS_ZERO;
        end else begin
          pos_adv_s[k*PW +: PW] = pos_r[k*PW +: PW] + POS_ONE;
        end
      end else begin
        pos_adv_s[k*PW +: PW] = pos_r[k*PW +: PW];
      end
      carry_s = carry_s && last_s[k];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s = CHECK;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CHECK: begin
          if (any_zero_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        RUN: begin
          if (xfer_s && all_last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // busy and done are registered copies of the next state so they line up
  // with the state register and come straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= (state_nxt_s == DONE);
    end
  end

  // Latched per-layer counts; later nhits changes do not affect the road.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {(NLAYER*PW){1'b0}};
    end else if (load_s) begin
      cnt_r <= nhits;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Offer register: positions and valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_r        <= {(NLAYER*PW){1'b0}};
      comb_valid_r <= 1'b0;
    end else if (abort) begin
      pos_r        <= pos_r;
      comb_valid_r <= 1'b0;
    end else if ((state_r == CHECK) && !any_zero_s) begin
      pos_r        <= {(NLAYER*PW){1'b0}};
      comb_valid_r <= 1'b1;
    end else if (xfer_s && all_last_s) begin
      pos_r        <= pos_r;
      comb_valid_r <= 1'b0;
    end else if (xfer_s) begin
      pos_r        <= pos_adv_s;
      comb_valid_r <= 1'b1;
    end else begin
      pos_r        <= pos_r;
      comb_valid_r <= comb_valid_r;
    end
  end

  // Empty-road flag, decided in CHECK and held until the next road's CHECK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nocomb_r <= 1'b0;
    end else if ((state_r == CHECK) && !abort) begin
      nocomb_r <= any_zero_s;
    end else begin
      nocomb_r <= nocomb_r;
    end
  end

  // Accepted-combination counter. A transfer coinciding with abort still
  // counts; the counter saturates instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ncomb_r <= {CW{1'b0}};
    end else if (load_s) begin
      ncomb_r <= {CW{1'b0}};
    end else if (xfer_s && (ncomb_r != NCOMB_MAX)) begin
      ncomb_r <= ncomb_r + NCOMB_ONE;
    end else begin
      ncomb_r <= ncomb_r;
    end
  end

  assign comb_valid = comb_valid_r;
  assign pos        = pos_r;
  assign comb_last  = comb_last_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign nocomb     = nocomb_r;
  assign ncomb      = ncomb_r;

endmodule

// File: tb/tb_hitcomb_seq.sv
// ----------------------------------------------------------------------------
// tb_hitcomb_seq
//
// Directed self-checking bench for hitcomb_seq. Two instances share inputs:
// the default one (CW=16) and a narrow-counter one (CW=4) for saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_hitcomb_seq;

  localparam int NLAYER = 6;
  localparam int PW     = 5;
  localparam int CW     = 16;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic [NLAYER*PW-1:0] nhits;
  logic                 abort;
  logic                 fit_ready;
  logic                 comb_valid;
  logic [NLAYER*PW-1:0] pos;
  logic                 comb_last;
  logic                 busy;
  logic                 done;
  logic                 nocomb;
  logic [CW-1:0]        ncomb;

  logic                 comb_valid4;
  logic [NLAYER*PW-1:0] pos4;
  logic                 comb_last4;
  logic                 busy4;
  logic                 done4;
  logic                 nocomb4;
  logic [3:0]           ncomb4;

  int checks = 0;
  int errors = 0;

  hitcomb_seq #(.NLAYER(NLAYER), .PW(PW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .nhits(nhits),
    .abort(abort), .fit_ready(fit_ready), .comb_valid(comb_valid),
    .pos(pos), .comb_last(comb_last), .busy(busy), .done(done),
    .nocomb(nocomb), .ncomb(ncomb)
  );

  hitcomb_seq #(.NLAYER(NLAYER), .PW(PW), .CW(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .nhits(nhits),
    .abort(abort), .fit_ready(fit_ready), .comb_valid(comb_valid4),
    .pos(pos4), .comb_last(comb_last4), .busy(busy4), .done(done4),
    .nocomb(nocomb4), .ncomb(ncomb4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [NLAYER*PW-1:0] mk(input int c0, input int c1, input int c2,
                                               input int c3, input int c4, input int c5);
    logic [NLAYER*PW-1:0] r;
    r = '0;
    r[0*PW +: PW] = PW'(c0);
    r[1*PW +: PW] = PW'(c1);
    r[2*PW +: PW] = PW'(c2);
    r[3*PW +: PW] = PW'(c3);
    r[4*PW +: PW] = PW'(c4);
    r[5*PW +: PW] = PW'(c5);
    return r;
  endfunction

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; fit_ready = 1'b0; nhits = '0;
    tick; tick;
    checks++;
    if ({comb_valid, comb_last, busy, done, nocomb} !== 5'b0 || pos !== '0 || ncomb !== '0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b last=%b busy=%b done=%b nocomb=%b pos=%h ncomb=%0d, want all 0",
               comb_valid, comb_last, busy, done, nocomb, pos, ncomb);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || comb_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy, comb_valid);
    end
  endtask

  // Runs one road with counts n0 (layer 0), n1 (layer 1), 1 elsewhere.
  // bp selects the 1,0,0 fit_ready pattern; disturb pulses start and
  // changes nhits in the middle of the road.
  task automatic run_road(input string nm, input int n0, input int n1,
                          input bit bp, input bit disturb);
    int  total;
    int  idx;
    int  c;
    bit  got_done;
    bit  disturbed;
    int  exp4;
    total = n0 * n1;
    exp4 = (total > 15) ? 15 : total;
    idx = 0; c = 0; got_done = 1'b0; disturbed = 1'b0;
    nhits = mk(n0, n1, 1, 1, 1, 1);
    fit_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || comb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after_start: got busy=%b valid=%b, want 1 0", nm, busy, comb_valid);
    end
    tick;
    checks++;
    if (comb_valid !== 1'b1 || pos !== '0) begin
      errors++;
      $display("FAIL %s_first_valid: got valid=%b pos=%h, want 1 0", nm, comb_valid, pos);
    end
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        checks++;
        if (idx != total || comb_valid !== 1'b0 || nocomb !== 1'b0) begin
          errors++;
          $display("FAIL %s_done: got transfers=%0d valid=%b nocomb=%b, want %0d 0 0",
                   nm, idx, comb_valid, nocomb, total);
        end
      end else if (comb_valid) begin
        checks++;
        if (pos !== mk(idx % n0, idx / n0, 0, 0, 0, 0) || comb_last !== (idx == total - 1)) begin
          errors++;
          $display("FAIL %s_comb%0d: got pos=%h last=%b, want pos=%h last=%b", nm, idx, pos,
                   comb_last, mk(idx % n0, idx / n0, 0, 0, 0, 0), (idx == total - 1));
        end
        if (disturb && idx == 2 && !disturbed) begin
          start = 1'b1;
          nhits = mk(2, 2, 2, 2, 2, 2);
          disturbed = 1'b1;
        end
        fit_ready = bp ? ((c % 3) == 0) : 1'b1;
        c++;
        if (fit_ready) idx++;
      end else begin
        checks++;
        errors++;
        $display("FAIL %s_gap: got valid=0 done=0 at transfer %0d, want valid or done", nm, idx);
        got_done = 1'b1;
      end
      if (!got_done) tick;
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, want done after %0d transfers", nm, total);
    end
    fit_ready = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ncomb !== CW'(total) || ncomb4 !== 4'(exp4)) begin
      errors++;
      $display("FAIL %s_end: got busy=%b done=%b ncomb=%0d ncomb4=%0d, want 0 0 %0d %0d",
               nm, busy, done, ncomb, ncomb4, total, exp4);
    end
  endtask

  task automatic test_minimal;
    run_road("minimal", 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_odometer;
    run_road("odometer", 3, 2, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_road("backpressure", 3, 2, 1'b1, 1'b0);
  endtask

  task automatic test_zero_hit;
    nhits = mk(4, 4, 4, 0, 4, 4);
    fit_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || comb_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_e0: got busy=%b done=%b valid=%b, want 1 0 0", busy, done, comb_valid);
    end
    tick;
    checks++;
    if (done !== 1'b1 || nocomb !== 1'b1 || comb_valid !== 1'b0 || ncomb !== '0) begin
      errors++;
      $display("FAIL zero_e1: got done=%b nocomb=%b valid=%b ncomb=%0d, want 1 1 0 0",
               done, nocomb, comb_valid, ncomb);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || comb_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_e2: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, comb_valid);
    end
    fit_ready = 1'b0;
  endtask

  task automatic test_abort_restart;
    nhits = mk(4, 4, 1, 1, 1, 1);
    fit_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick; tick; tick;
    checks++;
    if (comb_valid !== 1'b1 || pos !== mk(3, 0, 0, 0, 0, 0) || ncomb !== CW'(3)) begin
      errors++;
      $display("FAIL abort_pre: got valid=%b pos=%h ncomb=%0d, want 1 %h 3",
               comb_valid, pos, ncomb, mk(3, 0, 0, 0, 0, 0));
    end
    fit_ready = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (comb_valid !== 1'b0 || comb_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ncomb !== CW'(3)) begin
      errors++;
      $display("FAIL abort_post: got valid=%b last=%b done=%b busy=%b ncomb=%0d, want 0 0 0 0 3",
               comb_valid, comb_last, done, busy, ncomb);
    end
    tick;
    checks++;
    if (done !== 1'b0 || ncomb !== CW'(3)) begin
      errors++;
      $display("FAIL abort_no_done: got done=%b ncomb=%0d, want 0 3", done, ncomb);
    end
    run_road("restart", 4, 4, 1'b0, 1'b0);
  endtask

  task automatic test_robustness;
    nhits = mk(4, 4, 1, 1, 1, 1);
    fit_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    fit_ready = 1'b1;
    tick; tick;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({comb_valid, comb_last, busy, done, nocomb} !== 5'b0 || pos !== '0 || ncomb !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b last=%b busy=%b done=%b pos=%h ncomb=%0d, want all 0",
               comb_valid, comb_last, busy, done, pos, ncomb);
    end
    #1 reset = 1'b0;
    fit_ready = 1'b0;
    tick;
    run_road("disturb", 3, 2, 1'b0, 1'b1);
    run_road("saturate", 31, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_minimal;
    test_odometer;
    test_backpressure;
    test_zero_hit;
    test_abort_restart;
    test_robustness;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
